// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - descriptor-driven NoC packet injector feeding a router output-port arbiter
module noc_packet_injector #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [11:0]       desc_length_i,
    input  logic              pay_valid_i,
    output logic              pay_ready_o,
    input  logic [DATA_W-1:0] pay_data_i,
    input  logic              grant_i,
    output logic              req_o,
    output logic [2:0]        flit_id_o,
    output logic [11:0]       length_o,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic [DATA_W-1:0] flit_data_o,
    output logic              busy_o,
    output logic              drop_err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HEAD,
        S_BODY,
        S_TAIL
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       length_q, length_d;
    logic [11:0]       sent_q, sent_d;
    logic              drop_q, drop_d;
    logic [11:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              full, empty, push, pop, xfer;
    logic [11:0]       head_len;
    logic [DATA_W-1:0] data_sel;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign push     = desc_valid_i && !full;
    assign head_len = fifo_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        length_d     = length_q;
        sent_d       = sent_q;
        drop_d       = 1'b0;
        pop          = 1'b0;
        req_o        = 1'b0;
        flit_valid_o = 1'b0;
        flit_id_o    = 3'b000;
        pay_ready_o  = 1'b0;
        data_sel     = '0;
        xfer         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    sent_d = '0;
                    if (head_len < 12'd2) begin
                        drop_d = 1'b1;
                    end else begin
                        length_d = head_len;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                req_o = 1'b1;
                if (grant_i) state_d = S_HEAD;
            end
            S_HEAD: begin
                req_o        = 1'b1;
                flit_id_o    = 3'b001;
                flit_valid_o = grant_i;
                data_sel     = DATA_W'(length_q);
                xfer         = flit_valid_o && flit_ready_i && grant_i;
                if (xfer) begin
                    sent_d  = sent_q + 12'd1;
                    state_d = (length_q > 12'd2) ? S_BODY : S_TAIL;
                end
            end
            S_BODY, S_TAIL: begin
                req_o        = 1'b1;
                flit_id_o    = (state_q == S_BODY) ? 3'b010 : 3'b100;
                flit_valid_o = grant_i && pay_valid_i;
                data_sel     = pay_data_i;
                xfer         = flit_valid_o && flit_ready_i && grant_i;
                pay_ready_o  = xfer;
                if (xfer) begin
                    sent_d = sent_q + 12'd1;
                    if (state_q == S_TAIL) begin
                        state_d = S_IDLE;
                    end else if (sent_q + 12'd1 == length_q - 12'd1) begin
                        state_d = S_TAIL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            length_q <= '0;
            sent_q   <= '0;
            drop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            sent_q   <= sent_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= desc_length_i;
    end

    assign desc_ready_o = !full;
    assign length_o     = length_q;
    assign busy_o       = (state_q != S_IDLE);
    assign drop_err_o   = drop_q;
    assign flit_data_o  = flit_valid_o ? data_sel : '0;

endmodule

// File: tb/tb_noc_packet_injector.sv
// tb/tb_noc_packet_injector.sv - randomized self-checking bench for noc_packet_injector
module tb_noc_packet_injector;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        desc_valid, desc_ready;
    logic [11:0] desc_length;
    logic        pay_valid, pay_ready;
    logic [31:0] pay_data;
    logic        grant, req;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic        flit_valid, flit_ready;
    logic [31:0] flit_data;
    logic        busy, drop_err;

    always #5 clk = ~clk;

    noc_packet_injector #(.DATA_W(32), .DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_length_i(desc_length),
        .pay_valid_i(pay_valid), .pay_ready_o(pay_ready), .pay_data_i(pay_data),
        .grant_i(grant), .req_o(req), .flit_id_o(flit_id), .length_o(length),
        .flit_valid_o(flit_valid), .flit_ready_i(flit_ready), .flit_data_o(flit_data),
        .busy_o(busy), .drop_err_o(drop_err)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] payw [4096];
    int          pay_idx;
    int          pend_q[$];
    int          lens_q[$];
    logic [2:0]  obs_id[$], exp_id[$];
    logic [31:0] obs_data[$], exp_data[$];
    logic        tr_req[$];
    logic [2:0]  tr_id[$];
    int          viol, n_pay, n_drop, n_req_rise, n_acc, gap;
    logic        req_prev;
    int          grant_pct, pv_pct, fr_pct;
    bit          pv_toggle;

    task automatic drive_inputs();
        if (gap > 0) begin
            grant = 1'b0;
            gap--;
        end else begin
            grant = (int'($urandom_range(99)) < grant_pct);
        end
        pay_valid   = pv_toggle ? !pay_valid : (int'($urandom_range(99)) < pv_pct);
        flit_ready  = (int'($urandom_range(99)) < fr_pct);
        pay_data    = payw[pay_idx % 4096];
        desc_valid  = (pend_q.size() > 0);
        desc_length = desc_valid ? 12'(pend_q[0]) : 12'd0;
    endtask

    // One clock: observe at the falling edge, update bookkeeping and drive after the rising edge.
    task automatic tick();
        logic xfer_s, pay_take, desc_take;
        @(negedge clk);
        xfer_s = flit_valid && flit_ready && grant;
        if (xfer_s) begin
            obs_id.push_back(flit_id);
            obs_data.push_back(flit_data);
        end
        pay_take = pay_ready;
        if (pay_ready) n_pay++;
        if ((flit_id == 3'b010 || flit_id == 3'b100) && pay_ready !== xfer_s) viol++;
        if (flit_id != 3'b010 && flit_id != 3'b100 && pay_ready) viol++;
        if (flit_valid && flit_id != 3'b001 && !pay_valid) viol++;
        if (!flit_valid && flit_data !== 32'd0) viol++;
        if (req && !req_prev) n_req_rise++;
        req_prev = req;
        if (drop_err) n_drop++;
        tr_req.push_back(req);
        tr_id.push_back(flit_id);
        desc_take = desc_valid && desc_ready;
        @(posedge clk);
        #1;
        if (pay_take) pay_idx++;
        if (desc_take) begin
            void'(pend_q.pop_front());
            n_acc++;
        end
        drive_inputs();
    endtask

    // Reference: each kept descriptor yields a head carrying its length, then length-1
    // payload words in order, the last one tagged as tail.
    task automatic build_exp();
        int b;
        b = pay_idx;
        exp_id.delete();
        exp_data.delete();
        foreach (lens_q[i]) begin
            if (lens_q[i] >= 2) begin
                exp_id.push_back(3'b001);
                exp_data.push_back(32'(lens_q[i]));
                for (int k = 0; k < lens_q[i] - 1; k++) begin
                    exp_id.push_back((k == lens_q[i] - 2) ? 3'b100 : 3'b010);
                    exp_data.push_back(payw[(b + k) % 4096]);
                end
                b += lens_q[i] - 1;
            end
        end
        obs_id.delete();
        obs_data.delete();
    endtask

    function automatic int seq_diff();
        int d;
        d = 0;
        if (obs_id.size() != exp_id.size()) d++;
        for (int i = 0; i < obs_id.size() && i < exp_id.size(); i++)
            if (obs_id[i] !== exp_id[i] || obs_data[i] !== exp_data[i]) d++;
        return d;
    endfunction

    task automatic run_done(output bit to);
        int n;
        n = 0;
        to = 1'b0;
        while (!(pend_q.size() == 0 && obs_id.size() >= exp_id.size() && !busy)) begin
            tick();
            n++;
            if (n > 3000) begin
                to = 1'b1;
                break;
            end
        end
        repeat (6) tick();
    endtask

    task automatic set_knobs(input int g, input int p, input int f);
        grant_pct = g;
        pv_pct    = p;
        fr_pct    = f;
        pv_toggle = 1'b0;
        viol      = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req, flit_valid, flit_id, busy, drop_err, pay_ready, desc_ready} !== 9'b0_0_000_0_0_0_1) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000001", {req, flit_valid, flit_id, busy, drop_err, pay_ready, desc_ready});
        end
        checks++;
        if (length !== 12'd0 || flit_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got length=%0h data=%0h want 0 0", length, flit_data);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        drive_inputs();
        repeat (3) tick();
        checks++;
        if ({req, busy, desc_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want 001", {req, busy, desc_ready});
        end
    endtask

    task automatic test_len2();
        logic [5:0] rq;
        logic [17:0] ids;
        bit to;
        set_knobs(100, 100, 100);
        payw[pay_idx % 4096] = 32'h0000_00A5;
        lens_q = '{2};
        build_exp();
        pend_q = '{2};
        drive_inputs();
        tr_req.delete();
        tr_id.delete();
        repeat (6) tick();
        for (int i = 0; i < 6; i++) begin
            rq[5-i]          = tr_req[i];
            ids[17-3*i -: 3] = tr_id[i];
        end
        checks++;
        if (rq !== 6'b001110) begin
            errors++;
            $display("FAIL len2_req_trace: got %b want 001110", rq);
        end
        checks++;
        if (ids !== {3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000}) begin
            errors++;
            $display("FAIL len2_id_trace: got %o want 000140", ids);
        end
        run_done(to);
        checks++;
        if (seq_diff() != 0 || to) begin
            errors++;
            $display("FAIL len2_flits: got %0d diffs timeout=%0d want 0 0", seq_diff(), to);
        end
    endtask

    task automatic test_body_stall();
        int p0;
        bit to;
        set_knobs(100, 100, 100);
        pv_toggle = 1'b1;
        lens_q = '{5};
        build_exp();
        p0 = n_pay;
        pend_q = '{5};
        run_done(to);
        checks++;
        if (seq_diff() != 0 || to) begin
            errors++;
            $display("FAIL stall_flits: got %0d diffs timeout=%0d want 0 0", seq_diff(), to);
        end
        checks++;
        if (n_pay - p0 != 4) begin
            errors++;
            $display("FAIL stall_payload_count: got %0d want 4", n_pay - p0);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL stall_handshake: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_grant_loss();
        int n, bad;
        bit to;
        set_knobs(100, 100, 100);
        lens_q = '{6};
        build_exp();
        pend_q = '{6};
        n = 0;
        while (obs_id.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (obs_id.size() < 3) begin
            errors++;
            $display("FAIL gloss_reach_body: got %0d flits want 3", obs_id.size());
        end
        grant = 1'b0;
        gap   = 2;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (flit_valid !== 1'b0 || req !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gloss_gap: got %0d bad cycles want 0", bad);
        end
        run_done(to);
        checks++;
        if (seq_diff() != 0 || to) begin
            errors++;
            $display("FAIL gloss_flits: got %0d diffs timeout=%0d want 0 0", seq_diff(), to);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL gloss_handshake: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_fifo_full();
        int a0;
        bit to;
        set_knobs(0, 100, 100);
        grant = 1'b0;
        lens_q = '{2, 3, 4, 2, 3, 2};
        build_exp();
        a0 = n_acc;
        pend_q = '{2, 3, 4, 2, 3, 2};
        repeat (10) tick();
        checks++;
        if (n_acc - a0 != 5 || pend_q.size() != 1) begin
            errors++;
            $display("FAIL full_accepted: got %0d accepted want 5", n_acc - a0);
        end
        checks++;
        if (desc_ready !== 1'b0 || req !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_req: got ready=%b req=%b want 0 1", desc_ready, req);
        end
        grant_pct = 100;
        run_done(to);
        checks++;
        if (seq_diff() != 0 || to || n_acc - a0 != 6) begin
            errors++;
            $display("FAIL full_drain: got %0d diffs accepted=%0d timeout=%0d want 0 6 0", seq_diff(), n_acc - a0, to);
        end
    endtask

    task automatic test_drop();
        int d0, r0;
        bit to;
        set_knobs(100, 100, 100);
        lens_q = '{1, 3};
        build_exp();
        d0 = n_drop;
        r0 = n_req_rise;
        pend_q = '{1, 3};
        run_done(to);
        checks++;
        if (n_drop - d0 != 1) begin
            errors++;
            $display("FAIL drop_pulse: got %0d want 1", n_drop - d0);
        end
        checks++;
        if (n_req_rise - r0 != 1) begin
            errors++;
            $display("FAIL drop_req_count: got %0d want 1", n_req_rise - r0);
        end
        checks++;
        if (seq_diff() != 0 || to) begin
            errors++;
            $display("FAIL drop_flits: got %0d diffs timeout=%0d want 0 0", seq_diff(), to);
        end
    endtask

    task automatic test_random();
        int p0, d0, exp_pay, exp_drop, l;
        bit to;
        for (int r = 0; r < 5; r++) begin
            set_knobs(30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)));
            lens_q.delete();
            exp_pay  = 0;
            exp_drop = 0;
            for (int i = 0; i < 6; i++) begin
                l = int'($urandom_range(9));
                lens_q.push_back(l);
                if (l < 2) exp_drop++;
                else exp_pay += l - 1;
            end
            build_exp();
            p0 = n_pay;
            d0 = n_drop;
            pend_q = lens_q;
            run_done(to);
            checks++;
            if (seq_diff() != 0 || to) begin
                errors++;
                $display("FAIL rand%0d_flits: got %0d diffs timeout=%0d want 0 0", r, seq_diff(), to);
            end
            checks++;
            if (n_pay - p0 != exp_pay || n_drop - d0 != exp_drop) begin
                errors++;
                $display("FAIL rand%0d_counts: got pay=%0d drop=%0d want %0d %0d", r, n_pay - p0, n_drop - d0, exp_pay, exp_drop);
            end
            checks++;
            if (viol != 0) begin
                errors++;
                $display("FAIL rand%0d_handshake: got %0d violations want 0", r, viol);
            end
        end
    endtask

    task automatic test_async_reset();
        int n, r0;
        set_knobs(100, 100, 100);
        lens_q = '{8, 3};
        build_exp();
        pend_q = '{8, 3};
        n = 0;
        while (obs_id.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (obs_id.size() < 3 || pend_q.size() != 0 || flit_id !== 3'b010) begin
            errors++;
            $display("FAIL arst_setup: got flits=%0d pend=%0d id=%b want 3 0 010", obs_id.size(), pend_q.size(), flit_id);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req, flit_valid, flit_id, busy, pay_ready, desc_ready} !== 8'b0_0_000_0_0_1) begin
            errors++;
            $display("FAIL arst_ctrl: got %b want 00000001", {req, flit_valid, flit_id, busy, pay_ready, desc_ready});
        end
        checks++;
        if (length !== 12'd0 || flit_data !== 32'd0) begin
            errors++;
            $display("FAIL arst_data: got length=%0h data=%0h want 0 0", length, flit_data);
        end
        repeat (2) tick();
        rst_ni = 1'b1;
        lens_q.delete();
        build_exp();
        r0 = n_req_rise;
        repeat (15) tick();
        checks++;
        if (obs_id.size() != 0 || n_req_rise - r0 != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_fifo_empty: got flits=%0d req_rises=%0d busy=%b want 0 0 0", obs_id.size(), n_req_rise - r0, busy);
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        desc_valid  = 1'b0;
        desc_length = 12'd0;
        pay_valid   = 1'b0;
        pay_data    = 32'd0;
        grant       = 1'b0;
        flit_ready  = 1'b0;
        gap         = 0;
        pay_idx     = 0;
        viol        = 0;
        n_pay       = 0;
        n_drop      = 0;
        n_req_rise  = 0;
        n_acc       = 0;
        req_prev    = 1'b0;
        set_knobs(0, 0, 0);
        for (int i = 0; i < 4096; i++) payw[i] = $urandom;
        test_reset();
        test_len2();
        test_body_stall();
        test_grant_loss();
        test_fifo_full();
        test_drop();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
